// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - shared constants, chain word type and one-hot decode for the 74HC595 chain receiver
package hc595_pkg;

  localparam int NBITS_DEF = 24;
  localparam int RED_MSB   = 23;
  localparam int RED_LSB   = 16;
  localparam int GRN_MSB   = 7;
  localparam int GRN_LSB   = 0;
  localparam int COLS_DEF  = 8;
  localparam int IDX_W     = 3;

  typedef logic [NBITS_DEF-1:0] chain_word_t;

  // Returns {valid, idx}; valid is 1 only when exactly one bit of r is set.
  function automatic logic [IDX_W:0] onehot_idx(input logic [COLS_DEF-1:0] r);
    logic [IDX_W:0] res;
    int             cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < COLS_DEF; i++) begin
      if (r[i]) begin
        cnt++;
        res[IDX_W-1:0] = i[IDX_W-1:0];
      end
    end
    res[IDX_W] = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/hc595_chain_rx_if.sv
// rtl/hc595_chain_rx_if.sv - sampled 595 pins and reconstructed chain/frame results
interface hc595_chain_rx_if #(
  parameter int NBITS = 24,
  parameter int COLS  = 8
);

  logic               SH_CP;
  logic               ST_CP;
  logic               data;
  logic               MR;
  logic               OE;
  logic [COLS-1:0]    row;

  logic [NBITS-1:0]   q;
  logic               q_valid;
  logic [COLS*8-1:0]  frame_red;
  logic [COLS*8-1:0]  frame_green;
  logic               frame_valid;
  logic               overrun;
  logic               row_err;

  // Display driver side: drives the pins, observes the reconstruction.
  modport master (
    output SH_CP, ST_CP, data, MR, OE, row,
    input  q, q_valid, frame_red, frame_green, frame_valid, overrun, row_err
  );

  // Receiver side.
  modport slave (
    input  SH_CP, ST_CP, data, MR, OE, row,
    output q, q_valid, frame_red, frame_green, frame_valid, overrun, row_err
  );

endinterface

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - N-stage pin synchronizer with aligned level and registered rise pulse
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Synchronize the pin; level is one stage past the sync chain so that it
  // lines up with the registered rise pulse (latency SYNC_STAGES+1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/hc595_chain_rx.sv
// rtl/hc595_chain_rx.sv - oversampling receiver rebuilding the 595 chain and assembling red/green frames
module hc595_chain_rx
  import hc595_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = COLS_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  hc595_chain_rx_if.slave  bus
);

  localparam logic [4:0] CNT_FULL = 5'(NBITS);
  localparam logic [4:0] CNT_SAT  = 5'(NBITS + 1);

  logic            sh_rise, st_rise;
  logic            sh_s, st_s;
  logic            data_s, data_rise;
  logic            mr_n_s, mr_rise;
  logic            oe_n_s, oe_rise;
  logic [COLS-1:0] row_s, row_rise;
  logic [COLS+2:0] rise_unused;

  chain_word_t         sr;
  chain_word_t         storage;
  chain_word_t         latch_word;
  logic [4:0]          bit_cnt;
  logic [COLS-1:0]     slot_mask;
  logic [COLS-1:0]     mask_next;
  logic [COLS*8-1:0]   frame_red_r, frame_green_r;
  logic                q_valid_r, frame_valid_r, overrun_r, row_err_r;
  logic [IDX_W:0]      oh;
  logic [IDX_W-1:0]    idx;
  logic                row_ok;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sh (
    .clk(CLK), .rst(RST), .pin(bus.SH_CP), .level(sh_s), .rise(sh_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_st (
    .clk(CLK), .rst(RST), .pin(bus.ST_CP), .level(st_s), .rise(st_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data (
    .clk(CLK), .rst(RST), .pin(bus.data), .level(data_s), .rise(data_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mr (
    .clk(CLK), .rst(RST), .pin(bus.MR), .level(mr_n_s), .rise(mr_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_oe (
    .clk(CLK), .rst(RST), .pin(bus.OE), .level(oe_n_s), .rise(oe_rise));

  for (genvar i = 0; i < COLS; i++) begin : g_row
    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_row (
      .clk(CLK), .rst(RST), .pin(bus.row[i]), .level(row_s[i]), .rise(row_rise[i]));
  end

  // Only the clock pins need edges; the rest are consumed as aligned levels.
  assign rise_unused = {data_rise, mr_rise, oe_rise, row_rise, sh_s ^ st_s};

  // Column decode and the value a latch would capture (zero while MR is held low).
  always_comb begin
    oh         = onehot_idx(row_s);
    idx        = oh[IDX_W-1:0];
    row_ok     = oh[IDX_W];
    latch_word = mr_n_s ? sr : '0;
    mask_next  = slot_mask | (COLS'(1) << idx);
  end

  // Shift register, bit counter, storage, frame assembly and sticky flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr            <= '0;
      storage       <= '0;
      bit_cnt       <= '0;
      slot_mask     <= '0;
      frame_red_r   <= '0;
      frame_green_r <= '0;
      q_valid_r     <= 1'b0;
      frame_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
      row_err_r     <= 1'b0;
    end else begin
      q_valid_r     <= st_rise;
      frame_valid_r <= 1'b0;

      if (!mr_n_s) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (sh_rise) begin
        sr <= {sr[NBITS-2:0], data_s};
        if (st_rise) begin
          // Storage captured the pre-shift word; this shift starts a new one.
          bit_cnt <= 5'd1;
        end else begin
          if (bit_cnt == CNT_FULL) overrun_r <= 1'b1;
          if (bit_cnt != CNT_SAT)  bit_cnt   <= bit_cnt + 5'd1;
        end
      end else if (st_rise) begin
        bit_cnt <= '0;
      end

      if (st_rise) begin
        storage <= latch_word;
        if (row_ok) begin
          frame_red_r[idx*8 +: 8]   <= latch_word[RED_MSB:RED_LSB];
          frame_green_r[idx*8 +: 8] <= latch_word[GRN_MSB:GRN_LSB];
          if (&mask_next) begin
            frame_valid_r <= 1'b1;
            slot_mask     <= '0;
          end else begin
            slot_mask <= mask_next;
          end
        end else begin
          row_err_r <= 1'b1;
        end
      end
    end
  end

  assign bus.q           = oe_n_s ? '0 : storage;
  assign bus.q_valid     = q_valid_r;
  assign bus.frame_red   = frame_red_r;
  assign bus.frame_green = frame_green_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.overrun     = overrun_r;
  assign bus.row_err     = row_err_r;

endmodule

// File: tb/tb_hc595_chain_rx.sv
// tb/tb_hc595_chain_rx.sv - scoreboard bench for hc595_chain_rx
module tb_hc595_chain_rx;

  logic CLK = 1'b0;
  logic RST;

  hc595_chain_rx_if #(.NBITS(24), .COLS(8)) bus ();

  hc595_chain_rx dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] q;
    logic        fv;
    logic [63:0] red;
    logic [63:0] green;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_qv   = 0;
  int          n_push = 0;
  logic [63:0] exp_red   = '0;
  logic [63:0] exp_green = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every q_valid pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.q_valid) begin
        n_qv++;
        if (sb.size() == 0) begin
          check("unexpected q_valid", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("q", 64'(bus.q), 64'(mon_e.q));
          check("frame_valid", 64'(bus.frame_valid), 64'(mon_e.fv));
          check("frame_red", bus.frame_red, mon_e.red);
          check("frame_green", bus.frame_green, mon_e.green);
        end
      end else if (bus.frame_valid) begin
        check("stray frame_valid", 64'd1, 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic shift_bit(input logic b);
    bus.data = b;
    idle(2);
    bus.SH_CP = 1'b1;
    idle(3);
    bus.SH_CP = 1'b0;
    idle(3);
  endtask

  task automatic shift_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic push(input logic [23:0] q, input logic fv);
    exp_t e;
    e.q = q; e.fv = fv; e.red = exp_red; e.green = exp_green;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      idle(1);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic latch(input logic [23:0] q, input logic fv);
    push(q, fv);
    bus.ST_CP = 1'b1;
    idle(3);
    bus.ST_CP = 1'b0;
    idle(3);
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] k;
    RST = 1'b1;
    bus.SH_CP = 0; bus.ST_CP = 0; bus.data = 0; bus.MR = 1; bus.OE = 0; bus.row = '0;
    idle(3);
    check("reset q", 64'(bus.q), 64'd0);
    check("reset q_valid", 64'(bus.q_valid), 64'd0);
    check("reset frame_red", bus.frame_red, 64'd0);
    check("reset frame_green", bus.frame_green, 64'd0);
    check("reset flags", 64'({bus.frame_valid, bus.overrun, bus.row_err}), 64'd0);
    RST = 1'b0;
    idle(6);

    // Single word into column 2.
    bus.row = 8'b00000100;
    shift_word(24'h81003C);
    exp_red[23:16] = 8'h81; exp_green[23:16] = 8'h3C;
    latch(24'h81003C, 1'b0);

    // Walk all columns 7..0; red = index, green = ~index.
    for (int c = 7; c >= 0; c--) begin
      k = 8'(c);
      bus.row = 8'b1 << c;
      shift_word({k, 8'h00, ~k});
      exp_red[c*8 +: 8] = k; exp_green[c*8 +: 8] = ~k;
      latch({k, 8'h00, ~k}, c == 0);
    end
    check("full frame_red", bus.frame_red, 64'h0706050403020100);
    check("full frame_green", bus.frame_green, 64'hF8F9FAFBFCFDFEFF);

    // 25 shifts before a latch.
    bus.row = 8'b00000001;
    shift_bit(1'b1);
    shift_word(24'h123456);
    check("overrun set", 64'(bus.overrun), 64'd1);
    check("bit_cnt saturated", 64'(dut.bit_cnt), 64'd25);
    exp_red[7:0] = 8'h12; exp_green[7:0] = 8'h56;
    latch(24'h123456, 1'b0);
    check("overrun sticky", 64'(bus.overrun), 64'd1);

    // Simultaneous shift and latch.
    bus.row = 8'b00000010;
    shift_word(24'hFFFFFF);
    bus.data = 1'b0;
    idle(2);
    exp_red[15:8] = 8'hFF; exp_green[15:8] = 8'hFF;
    push(24'hFFFFFF, 1'b0);
    bus.SH_CP = 1'b1; bus.ST_CP = 1'b1;
    idle(3);
    bus.SH_CP = 1'b0; bus.ST_CP = 1'b0;
    idle(3);
    drain();
    check("sr after simultaneous", 64'(dut.sr), 64'hFFFFFE);
    check("bit_cnt after simultaneous", 64'(dut.bit_cnt), 64'd1);

    // MR low: shifts ignored, latch loads zero.
    bus.MR = 1'b0;
    idle(4);
    for (int i = 0; i < 10; i++) shift_bit(1'b1);
    check("sr held by MR", 64'(dut.sr), 64'd0);
    check("bit_cnt held by MR", 64'(dut.bit_cnt), 64'd0);
    bus.row = 8'b00010000;
    exp_red[39:32] = 8'h00; exp_green[39:32] = 8'h00;
    latch(24'h000000, 1'b0);
    bus.MR = 1'b1;
    idle(4);
    bus.row = 8'b00001000;
    shift_word(24'hA5005A);
    exp_red[31:24] = 8'hA5; exp_green[31:24] = 8'h5A;
    latch(24'hA5005A, 1'b0);
    bus.OE = 1'b1;
    idle(6);
    check("q gated by OE", 64'(bus.q), 64'd0);
    bus.OE = 1'b0;
    idle(6);
    check("q restored after OE", 64'(bus.q), 64'hA5005A);

    // Bad row selects.
    bus.row = 8'b00000000;
    shift_word(24'h0F00F0);
    latch(24'h0F00F0, 1'b0);
    check("row_err on zero row", 64'(bus.row_err), 64'd1);
    bus.row = 8'b00100001;
    idle(4);
    latch(24'h0F00F0, 1'b0);
    check("row_err sticky", 64'(bus.row_err), 64'd1);
    check("overrun still sticky", 64'(bus.overrun), 64'd1);
    check("q_valid pulse count", 64'(n_qv), 64'(n_push));

    // Reset mid-word.
    bus.row = 8'b00100000;
    for (int i = 0; i < 12; i++) shift_bit(1'b1);
    #2;
    RST = 1'b1;
    #1;
    check("async reset q", 64'(bus.q), 64'd0);
    check("async reset frames", bus.frame_red | bus.frame_green, 64'd0);
    check("async reset flags", 64'({bus.q_valid, bus.frame_valid, bus.overrun, bus.row_err}), 64'd0);
    idle(2);
    RST = 1'b0;
    idle(6);
    exp_red = '0; exp_green = '0;
    for (int i = 7; i >= 0; i--) shift_bit(1'(8'hC3 >> i));
    exp_green[47:40] = 8'hC3;
    latch(24'h0000C3, 1'b0);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
